// File: rtl/mii_mgmt_master.sv
// Clause 22 MDIO management master: serialises single read/write commands and
// runs an optional background link-status scan over a range of PHY addresses.
module mii_mgmt_master #(
  parameter int DIV_W  = 8,
  parameter int DATA_W = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [DIV_W-1:0]  divider,
  input  logic              no_pre,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [4:0]        cmd_phy,
  input  logic [4:0]        cmd_reg,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  input  logic              scan_en,
  input  logic [4:0]        scan_phy_first,
  input  logic [4:0]        scan_phy_last,
  input  logic [4:0]        scan_reg,
  input  logic [DATA_W-1:0] scan_mask,
  output logic              scan_valid,
  output logic [4:0]        scan_phy,
  output logic [DATA_W-1:0] scan_data,
  input  logic              int_clr,
  output logic              int_o,
  output logic              mdc_pad_o,
  output logic              md_pad_o,
  output logic              md_padoe_o,
  input  logic              md_pad_i
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, TURN, DATA} state_t;

  state_t             state_reg;
  logic [DIV_W-1:0]   div_reg;
  logic [DIV_W-1:0]   div_cnt_reg;
  logic [5:0]         bit_cnt_reg;
  logic [63:0]        shift_reg;
  logic               no_pre_reg;
  logic               write_reg;
  logic               scan_frame_reg;
  logic               scan_run_reg;
  logic [4:0]         scan_cur_reg;
  logic [4:0]         frame_phy_reg;
  logic [DATA_W-1:0]  rx_reg;

  logic [DIV_W-1:0]   div_eff;
  logic [5:0]         last_bit;
  logic [5:0]         pre_len;
  logic [5:0]         ta_start;
  logic [5:0]         bit_nxt;
  state_t             phase_nxt;
  logic [4:0]         scan_start_phy;
  logic [4:0]         scan_next;
  logic [31:0]        core_frame;
  logic [63:0]        start_frame;

  always_comb begin
    div_eff        = (divider < DIV_W'(2)) ? DIV_W'(2) : divider;
    last_bit       = no_pre_reg ? 6'd31 : 6'd63;
    pre_len        = no_pre_reg ? 6'd0 : 6'd32;
    ta_start       = pre_len + 6'd14;
    bit_nxt        = bit_cnt_reg + 6'd1;
    scan_start_phy = scan_run_reg ? scan_cur_reg : scan_phy_first;
    // Out-of-range or last address wraps; an inverted range degenerates to first.
    scan_next      = (frame_phy_reg < scan_phy_first || frame_phy_reg >= scan_phy_last) ?
                     scan_phy_first : frame_phy_reg + 5'd1;

    phase_nxt = DATA;
    if (bit_nxt < pre_len)
      phase_nxt = PREAMBLE;
    else if (bit_nxt < ta_start)
      phase_nxt = HEADER;
    else if (bit_nxt < ta_start + 6'd2)
      phase_nxt = TURN;

    if (cmd_valid)
      core_frame = {2'b01, cmd_write ? 2'b01 : 2'b10, cmd_phy, cmd_reg,
                    cmd_write ? {2'b10, cmd_wdata} : 18'h0};
    else
      core_frame = {2'b01, 2'b10, scan_start_phy, scan_reg, 18'h0};

    // Short frames are left-aligned so the serialiser always emits from bit 63.
    start_frame = no_pre ? {core_frame, 32'h0} : {32'hFFFF_FFFF, core_frame};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg      <= IDLE;
      div_reg        <= '0;
      div_cnt_reg    <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      no_pre_reg     <= 1'b0;
      write_reg      <= 1'b0;
      scan_frame_reg <= 1'b0;
      scan_run_reg   <= 1'b0;
      scan_cur_reg   <= '0;
      frame_phy_reg  <= '0;
      rx_reg         <= '0;
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      busy           <= 1'b0;
      scan_valid     <= 1'b0;
      scan_phy       <= '0;
      scan_data      <= '0;
      int_o          <= 1'b0;
      mdc_pad_o      <= 1'b0;
      md_pad_o       <= 1'b0;
      md_padoe_o     <= 1'b0;
    end else begin
      rsp_valid  <= 1'b0;
      scan_valid <= 1'b0;
      if (int_clr)
        int_o <= 1'b0;

      case (state_reg)
        IDLE: begin
          mdc_pad_o   <= 1'b0;
          div_cnt_reg <= '0;
          if (!scan_en)
            scan_run_reg <= 1'b0;
          // The first idle cycle after a frame only re-arms cmd_ready.
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid || scan_en) begin
            state_reg      <= no_pre ? HEADER : PREAMBLE;
            shift_reg      <= start_frame;
            md_pad_o       <= start_frame[63];
            md_padoe_o     <= 1'b1;
            busy           <= 1'b1;
            cmd_ready      <= 1'b0;
            div_reg        <= div_eff;
            bit_cnt_reg    <= '0;
            no_pre_reg     <= no_pre;
            write_reg      <= cmd_valid & cmd_write;
            scan_frame_reg <= ~cmd_valid;
            frame_phy_reg  <= cmd_valid ? cmd_phy : scan_start_phy;
            if (!cmd_valid)
              scan_run_reg <= 1'b1;
          end
        end

        default: begin
          if (div_cnt_reg == div_reg - DIV_W'(1)) begin
            div_cnt_reg <= '0;
            if (!mdc_pad_o) begin
              mdc_pad_o <= 1'b1;
              if (state_reg == DATA)
                rx_reg <= {rx_reg[DATA_W-2:0], md_pad_i};
            end else if (bit_cnt_reg == last_bit) begin
              state_reg  <= IDLE;
              mdc_pad_o  <= 1'b0;
              md_pad_o   <= 1'b0;
              md_padoe_o <= 1'b0;
              busy       <= 1'b0;
              if (scan_frame_reg) begin
                scan_valid   <= 1'b1;
                scan_phy     <= frame_phy_reg;
                scan_data    <= rx_reg;
                scan_cur_reg <= scan_next;
                if ((rx_reg & scan_mask) == '0)
                  int_o <= 1'b1;
              end else begin
                rsp_valid <= 1'b1;
                if (!write_reg)
                  rsp_rdata <= rx_reg;
              end
            end else begin
              mdc_pad_o   <= 1'b0;
              bit_cnt_reg <= bit_nxt;
              shift_reg   <= {shift_reg[62:0], 1'b0};
              md_pad_o    <= shift_reg[62];
              md_padoe_o  <= write_reg || (bit_nxt < ta_start);
              state_reg   <= phase_nxt;
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mii_mgmt_master.sv
// Directed bench for mii_mgmt_master with a behavioural PHY that answers reads
// from a per-address table and records the MDIO bits driven by the master.
module tb_mii_mgmt_master;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic [7:0]  divider;
  logic        no_pre;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_phy;
  logic [4:0]  cmd_reg;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic        scan_en;
  logic [4:0]  scan_phy_first;
  logic [4:0]  scan_phy_last;
  logic [4:0]  scan_reg;
  logic [15:0] scan_mask;
  logic        scan_valid;
  logic [4:0]  scan_phy;
  logic [15:0] scan_data;
  logic        int_clr;
  logic        int_o;
  logic        mdc_pad_o;
  logic        md_pad_o;
  logic        md_padoe_o;
  logic        md_pad_i;

  always #5 clk = ~clk;

  mii_mgmt_master #(.DIV_W(8), .DATA_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .divider(divider), .no_pre(no_pre),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .scan_en(scan_en), .scan_phy_first(scan_phy_first), .scan_phy_last(scan_phy_last),
    .scan_reg(scan_reg), .scan_mask(scan_mask), .scan_valid(scan_valid),
    .scan_phy(scan_phy), .scan_data(scan_data), .int_clr(int_clr), .int_o(int_o),
    .mdc_pad_o(mdc_pad_o), .md_pad_o(md_pad_o), .md_padoe_o(md_padoe_o),
    .md_pad_i(md_pad_i)
  );

  // PHY model: capture driven bits on MDC rise, answer reads after turnaround.
  logic [15:0] phy_data [0:31];
  logic        mdc_q = 1'b0;
  int          phy_rise = 0;
  logic [63:0] cap = '0;
  int          cap_n = 0;
  logic [15:0] phy_pick;

  always @(posedge clk) begin
    mdc_q <= mdc_pad_o;
    if (mdc_pad_o && !mdc_q && md_padoe_o) begin
      cap   <= {cap[62:0], md_pad_o};
      cap_n <= cap_n + 1;
    end
    if (md_padoe_o)
      phy_rise <= 0;
    else if (mdc_pad_o && !mdc_q)
      phy_rise <= phy_rise + 1;
  end

  assign phy_pick = phy_data[cap[9:5]];
  assign md_pad_i = (!md_padoe_o && phy_rise >= 2 && phy_rise <= 17) ?
                    phy_pick[4'(17 - phy_rise)] : 1'b1;

  int   checks = 0;
  int   errors = 0;
  int   lat, acc_wait, first_rise, second_rise, first_oe_low, oe_low_n;
  logic busy_t0;

  // Issues one command and measures its frame; called #1 after a clock edge.
  task automatic run_cmd(input logic w, input logic [4:0] phy, input logic [4:0] rg,
                         input logic [15:0] wd);
    int   cyc;
    logic prev_mdc;
    cmd_write = w; cmd_phy = phy; cmd_reg = rg; cmd_wdata = wd; cmd_valid = 1'b1;
    acc_wait = 0;
    while (!cmd_ready && acc_wait < 5000) begin
      @(posedge clk); #1; acc_wait++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    busy_t0 = busy;
    cyc = 0; first_rise = -1; second_rise = -1; first_oe_low = -1; oe_low_n = 0;
    prev_mdc = 1'b0;
    while (!rsp_valid && cyc < 5000) begin
      if (mdc_pad_o && !prev_mdc) begin
        if (first_rise < 0) first_rise = cyc;
        else if (second_rise < 0) second_rise = cyc;
      end
      prev_mdc = mdc_pad_o;
      if (!md_padoe_o) begin
        oe_low_n++;
        if (first_oe_low < 0) first_oe_low = cyc;
      end
      @(posedge clk); #1; cyc++;
    end
    lat = rsp_valid ? cyc : -1;
    $display("txn write=%0b phy=%0d reg=%0d wdata=%h lat=%0d rdata=%h",
             w, phy, rg, wd, lat, rsp_rdata);
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    wb_rst_i = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (mdc_pad_o !== 1'b0) begin errors++; $display("FAIL reset_mdc got %b exp 0", mdc_pad_o); end
    checks++; if (md_padoe_o !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", md_padoe_o); end
    checks++; if (md_pad_o !== 1'b0) begin errors++; $display("FAIL reset_md got %b exp 0", md_pad_o); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0000", rsp_rdata); end
    checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL reset_scan_valid got %b exp 0", scan_valid); end
    checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL reset_int got %b exp 0", int_o); end
  endtask

  task automatic test_write();
    int n0;
    divider = 8'd2; no_pre = 1'b0;
    n0 = cap_n;
    run_cmd(1'b1, 5'h01, 5'h04, 16'h01E1);
    checks++; if (lat !== 256) begin errors++; $display("FAIL write_latency got %0d exp 256", lat); end
    checks++; if (busy_t0 !== 1'b1) begin errors++; $display("FAIL write_busy_t0 got %b exp 1", busy_t0); end
    checks++; if (oe_low_n !== 0) begin errors++; $display("FAIL write_oe_low got %0d exp 0", oe_low_n); end
    checks++; if (second_rise - first_rise !== 4) begin errors++; $display("FAIL write_mdc_period got %0d exp 4", second_rise - first_rise); end
    checks++; if (cap_n - n0 !== 64) begin errors++; $display("FAIL write_bit_count got %0d exp 64", cap_n - n0); end
    checks++; if (cap !== 64'hFFFF_FFFF_5092_01E1) begin errors++; $display("FAIL write_stream got %h exp ffffffff509201e1", cap); end
    checks++; if (busy !== 1'b0 || md_padoe_o !== 1'b0 || mdc_pad_o !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL write_done_pins got busy=%b oe=%b mdc=%b rdy=%b exp 0 0 0 0", busy, md_padoe_o, mdc_pad_o, cmd_ready);
    end
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL write_ready_after got %b exp 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL write_rsp_pulse got %b exp 0", rsp_valid); end
  endtask

  task automatic test_read();
    divider = 8'd4; no_pre = 1'b1;
    run_cmd(1'b0, 5'h1F, 5'h01, 16'h0000);
    checks++; if (lat !== 256) begin errors++; $display("FAIL read_latency got %0d exp 256", lat); end
    checks++; if (rsp_rdata !== 16'h796D) begin errors++; $display("FAIL read_data got %h exp 796d", rsp_rdata); end
    checks++; if (first_oe_low !== 112) begin errors++; $display("FAIL read_oe_drop got %0d exp 112", first_oe_low); end
    checks++; if (oe_low_n !== 144) begin errors++; $display("FAIL read_oe_low_cycles got %0d exp 144", oe_low_n); end
    checks++; if (first_rise !== 4) begin errors++; $display("FAIL read_first_rise got %0d exp 4", first_rise); end
    checks++; if (second_rise - first_rise !== 8) begin errors++; $display("FAIL read_mdc_period got %0d exp 8", second_rise - first_rise); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_clamp();
    no_pre = 1'b1;
    for (int d = 0; d < 2; d++) begin
      divider = 8'(d);
      run_cmd(1'b1, 5'h02, 5'h00, 16'h1234);
      checks++; if (lat !== 128) begin errors++; $display("FAIL clamp_latency div=%0d got %0d exp 128", d, lat); end
      checks++; if (second_rise - first_rise !== 4) begin errors++; $display("FAIL clamp_period div=%0d got %0d exp 4", d, second_rise - first_rise); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_scan();
    logic [4:0]  exp_phy [4] = '{5'd2, 5'd3, 5'd4, 5'd2};
    logic [15:0] exp_dat [4] = '{16'h0004, 16'h0000, 16'h0004, 16'h0004};
    logic        exp_int [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [4:0]  sp [4] = '{default: '0};
    logic [15:0] sd [4] = '{default: '0};
    logic        si [4] = '{default: 1'b0};
    int          sc [4] = '{default: 0};
    int          n = 0, k = 0, rsp_seen = 0;
    divider = 8'd2; no_pre = 1'b1;
    scan_phy_first = 5'd2; scan_phy_last = 5'd4; scan_reg = 5'd1; scan_mask = 16'h0004;
    scan_en = 1'b1;
    while (k < 4 && n < 2000) begin
      @(posedge clk); #1; n++;
      if (rsp_valid) rsp_seen++;
      if (scan_valid) begin
        sp[k] = scan_phy; sd[k] = scan_data; si[k] = int_o; sc[k] = n;
        $display("scan phy=%0d data=%h int=%b", scan_phy, scan_data, int_o);
        k++;
        if (k == 4) scan_en = 1'b0;
      end
    end
    checks++; if (k !== 4) begin errors++; $display("FAIL scan_count got %0d exp 4", k); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (sp[i] !== exp_phy[i]) begin errors++; $display("FAIL scan_phy[%0d] got %0d exp %0d", i, sp[i], exp_phy[i]); end
      checks++; if (sd[i] !== exp_dat[i]) begin errors++; $display("FAIL scan_data[%0d] got %h exp %h", i, sd[i], exp_dat[i]); end
      checks++; if (si[i] !== exp_int[i]) begin errors++; $display("FAIL scan_int[%0d] got %b exp %b", i, si[i], exp_int[i]); end
    end
    checks++; if (sc[1] - sc[0] !== 130) begin errors++; $display("FAIL scan_spacing got %0d exp 130", sc[1] - sc[0]); end
    checks++; if (rsp_seen !== 0) begin errors++; $display("FAIL scan_rsp_valid got %0d exp 0", rsp_seen); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL scan_stop_busy got %b exp 0", busy); end
    checks++; if (int_o !== 1'b1) begin errors++; $display("FAIL scan_int_sticky got %b exp 1", int_o); end
    int_clr = 1'b1;
    @(posedge clk); #1;
    int_clr = 1'b0;
    checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL scan_int_clr got %b exp 0", int_o); end
  endtask

  task automatic test_scan_inverted();
    int n = 0, k = 0;
    logic [4:0] sp [2] = '{default: '0};
    scan_phy_first = 5'd4; scan_phy_last = 5'd3;
    scan_en = 1'b1;
    while (k < 2 && n < 1000) begin
      @(posedge clk); #1; n++;
      if (scan_valid) begin
        sp[k] = scan_phy; k++;
        if (k == 2) scan_en = 1'b0;
      end
    end
    checks++; if (k !== 2) begin errors++; $display("FAIL inv_count got %0d exp 2", k); end
    checks++; if (sp[0] !== 5'd4 || sp[1] !== 5'd4) begin errors++; $display("FAIL inv_phy got %0d,%0d exp 4,4", sp[0], sp[1]); end
    checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL inv_int got %b exp 0", int_o); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_int_clr_collision();
    int n = 0;
    logic seen = 1'b0;
    scan_phy_first = 5'd3; scan_phy_last = 5'd3;
    int_clr = 1'b1;
    scan_en = 1'b1;
    while (!seen && n < 1000) begin
      @(posedge clk); #1; n++;
      if (scan_valid) seen = 1'b1;
    end
    scan_en = 1'b0;
    checks++; if (!seen || int_o !== 1'b1) begin errors++; $display("FAIL int_set_wins got seen=%b int=%b exp 1 1", seen, int_o); end
    @(posedge clk); #1;
    checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL int_clr_after got %b exp 0", int_o); end
    int_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_cmd_during_scan();
    int n = 0, cyc = 0, acc_c = -1, sv1 = -1, rsp_c = -1, sv2 = -1, sv_between = 0;
    logic drop = 1'b0;
    logic [4:0]  sv2_phy = '0;
    logic [15:0] rd = '0;
    scan_phy_first = 5'd2; scan_phy_last = 5'd4;
    scan_en = 1'b1;
    while (!busy && n < 100) begin
      @(posedge clk); #1; n++;
    end
    repeat (20) @(posedge clk);
    #1;
    cmd_write = 1'b0; cmd_phy = 5'd5; cmd_reg = 5'd2; cmd_wdata = 16'h0; cmd_valid = 1'b1;
    while (sv2 < 0 && cyc < 3000) begin
      @(posedge clk); #1; cyc++;
      if (drop) begin cmd_valid = 1'b0; drop = 1'b0; end
      if (scan_valid) begin
        if (sv1 < 0) sv1 = cyc;
        else if (rsp_c < 0) sv_between++;
        else begin sv2 = cyc; sv2_phy = scan_phy; scan_en = 1'b0; end
      end
      if (rsp_valid) begin rsp_c = cyc; rd = rsp_rdata; end
      if (cmd_valid && cmd_ready) begin acc_c = cyc; drop = 1'b1; end
    end
    scan_en = 1'b0;
    cmd_valid = 1'b0;
    $display("txn mid-scan read phy=5 accept=%0d rsp=%0d rdata=%h", acc_c, rsp_c, rd);
    checks++; if (acc_c !== sv1 + 1 || sv1 < 0) begin errors++; $display("FAIL midscan_accept got %0d exp %0d", acc_c, sv1 + 1); end
    checks++; if (rsp_c !== acc_c + 129) begin errors++; $display("FAIL midscan_rsp_time got %0d exp %0d", rsp_c, acc_c + 129); end
    checks++; if (rd !== 16'hA55A) begin errors++; $display("FAIL midscan_rdata got %h exp a55a", rd); end
    checks++; if (sv_between !== 0) begin errors++; $display("FAIL midscan_overlap got %0d exp 0", sv_between); end
    checks++; if (sv2 !== rsp_c + 130) begin errors++; $display("FAIL midscan_resume got %0d exp %0d", sv2, rsp_c + 130); end
    checks++; if (sv2_phy !== 5'd3) begin errors++; $display("FAIL midscan_next_phy got %0d exp 3", sv2_phy); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midframe();
    int n = 0, rsp_seen = 0;
    divider = 8'd2; no_pre = 1'b1;
    cmd_write = 1'b0; cmd_phy = 5'h1F; cmd_reg = 5'h01; cmd_wdata = 16'h0; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    wb_rst_i = 1'b1;
    @(posedge clk); #1;
    wb_rst_i = 1'b0;
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl got rdy=%b busy=%b exp 1 0", cmd_ready, busy); end
    checks++; if (mdc_pad_o !== 1'b0 || md_pad_o !== 1'b0 || md_padoe_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_pins got mdc=%b md=%b oe=%b exp 0 0 0", mdc_pad_o, md_pad_o, md_padoe_o);
    end
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0) begin errors++; $display("FAIL rst_mid_rsp got %b %h exp 0 0000", rsp_valid, rsp_rdata); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) rsp_seen++;
    end
    checks++; if (rsp_seen !== 0) begin errors++; $display("FAIL rst_mid_no_rsp got %0d exp 0", rsp_seen); end
    run_cmd(1'b0, 5'd5, 5'd2, 16'h0000);
    checks++; if (acc_wait !== 0) begin errors++; $display("FAIL rst_mid_accept_wait got %0d exp 0", acc_wait); end
    checks++; if (lat !== 128) begin errors++; $display("FAIL rst_mid_latency got %0d exp 128", lat); end
    checks++; if (rsp_rdata !== 16'hA55A) begin errors++; $display("FAIL rst_mid_rdata got %h exp a55a", rsp_rdata); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) phy_data[i] = 16'hFFFF;
    phy_data[2]  = 16'h0004;
    phy_data[3]  = 16'h0000;
    phy_data[4]  = 16'h0004;
    phy_data[5]  = 16'hA55A;
    phy_data[31] = 16'h796D;
    wb_rst_i = 1'b1; divider = 8'd2; no_pre = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_phy = '0; cmd_reg = '0; cmd_wdata = '0;
    scan_en = 1'b0; scan_phy_first = '0; scan_phy_last = '0; scan_reg = '0; scan_mask = '0;
    int_clr = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_div_clamp();
    test_scan();
    test_scan_inverted();
    test_int_clr_collision();
    test_cmd_during_scan();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
